pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, elastic inter-stage pipeline register that replaces the fixed-width, freeze-only stage registers between IF/ID/EX/MEM/WB. It carries an arbitrary-width payload through `DEPTH` register slots with per-slot valid bits, a valid/ready handshake, freeze (stall) and flush (squash), and saturating stall/flush event counters for profiling. One instance sits at every stage boundary of the MIPS pipeline; the payload is the concatenated control, operand and instruction fields of the upstream stage.

## Interface
Parameters:
- `DATA_W`, 57, payload width in bits (≥1)
- `DEPTH`, 1, number of register slots (1..4)
- `CNT_W`, 16, width of each event counter (≥2)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset (clears state immediately when low)
- `in_valid`  in  1  upstream payload valid
- `in_data`  in  DATA_W  upstream payload
- `in_ready`  out  1  slot 0 can accept this cycle
- `out_valid`  out  1  last slot holds valid payload and stage not frozen
- `out_data`  out  DATA_W  payload of last slot
- `out_ready`  in  1  downstream accepts this cycle
- `freeze`  in  1  hazard-unit stall; holds all slots
- `flush`  in  1  squash all slots (branch taken / exception)
- `cnt_clr`  in  1  synchronous clear of both counters
- `stall_cnt`  out  CNT_W  saturating count of stalled cycles
- `flush_cnt`  out  CNT_W  saturating count of flush cycles

## Operation
- State: slot payload `d[i]` (DATA_W) and valid `v[i]`, i = 0..DEPTH-1; slot DEPTH-1 drives outputs.
- Accept chain (combinational): `acc[DEPTH] = out_ready`; `acc[i] = !v[i] || acc[i+1]`. Bubble-collapsing: an empty slot always accepts.
- `in_ready = !freeze && !flush && acc[0]`; `out_valid = v[DEPTH-1] && !freeze`; `out_data = d[DEPTH-1]`.
- Priority per cycle: reset > flush > freeze > normal advance.
- Flush: all `v[i]` ← 0, all `d[i]` ← 0; concurrent input is discarded; applies even when frozen.
- Freeze (no flush): no slot changes; no input or output transfer occurs.
- Normal: slot i with `acc[i]` loads from slot i-1 (slot 0 from `in_data`/`in_valid`); when it loads an invalid source, `v[i]` ← 0 and `d[i]` holds its old value. Slots with `!acc[i]` hold.
- Output transfer = `out_valid && out_ready`; input transfer = `in_valid && in_ready`.
- `stall_cnt` +1 each cycle where `freeze`, or `v[DEPTH-1] && !out_ready`; saturates at all-ones.
- `flush_cnt` +1 each cycle `flush` is high; saturates at all-ones.
- `cnt_clr` zeroes both counters that cycle, overriding increment.
- Ordering of payload strictly preserved; no payload duplicated or lost except on flush.

## Timing
- Reset (rst low, async): all `v` = 0, all `d` = 0, counters = 0 → `out_valid` 0, `out_data` 0, `in_ready` 1 (if `freeze`, `flush` low), `stall_cnt`/`flush_cnt` 0. Release synchronised externally; first update on first rising edge with rst high.
- Latency: DEPTH cycles from input transfer to `out_valid` with no backpressure.
- Throughput: 1 transfer/cycle while `out_ready` held high; full pipeline with `out_ready` low takes exactly DEPTH more inputs after emptying, then `in_ready` drops combinationally.
- `in_ready` depends combinationally on `out_ready`, `freeze`, `flush`; no combinational path from `in_data` to any output.
- Full + simultaneous in/out transfer: accepted (pass-through of shift), occupancy unchanged.
- Reset asserted mid-stream: all in-flight payload lost, no partial state.
- Freeze and flush released same cycle: advance resumes next edge from cleared state.

## Structure
- Shared package `pipe_pkg`: `PIPE_MAX_DEPTH = 4`, default counter width, and the saturating-increment function used by both counters.
- One sub-module natural: `pipe_slot` (single payload+valid register with load/clear enables, async active-low reset); `pipe_stage_reg` generates DEPTH instances and the accept chain.
- Counters stay in the top module.

## Test plan
- Reset: drive rst low mid-stream with DEPTH=2, 2 valid slots → `out_valid`=0, `out_data`=0, counters 0 immediately, before next edge.
- Streaming: DEPTH=3, `out_ready`=1, inputs 1,2,3,4 back-to-back → outputs 1,2,3,4 on cycles 3..6, `in_ready` constant 1, `stall_cnt`=0.
- Backpressure: DEPTH=2, `out_ready`=0, send A,B,C → A,B accepted, `in_ready`=0 on C; raise `out_ready` → A then B then C delivered in order, `stall_cnt` equals cycles with `out_ready` low and valid output.
- Freeze: hold `freeze` 3 cycles with full pipe → `out_valid`=0, `in_ready`=0, contents unchanged, `stall_cnt`+3; release → same payload emerges.
- Flush vs freeze: assert `flush` and `freeze` together with `in_valid`=1 → all slots empty next cycle, input dropped, `flush_cnt`=1.
- Saturation: CNT_W=2, freeze 6 cycles → `stall_cnt`=3; `cnt_clr` pulse → 0.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Definitions shared by the elastic pipeline stage register and its slot.
//   PIPE_MAX_DEPTH : largest number of register slots a stage may carry
//   PIPE_CNT_W     : default width of the profiling event counters
//   PIPE_CNT_MAX_W : widest counter the saturating helper supports
//   stage_mode_e   : per-cycle operating mode after priority resolution
//   sat_inc()      : saturating increment used by both event counters
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int PIPE_MAX_DEPTH = 4;
  localparam int PIPE_CNT_W     = 16;
  localparam int PIPE_CNT_MAX_W = 64;

  // Flush beats freeze, freeze beats normal advance.
  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_FREEZE = 2'd1,
    MODE_FLUSH  = 2'd2
  } stage_mode_e;

  // Increment 'value' unless it already holds the all-ones pattern of a
  // 'width'-bit counter. The value travels in a wide container so that one
  // function serves every counter width up to PIPE_CNT_MAX_W.
  function automatic logic [PIPE_CNT_MAX_W-1:0] sat_inc(
    input logic [PIPE_CNT_MAX_W-1:0] value,
    input int                        width
  );
    logic [PIPE_CNT_MAX_W-1:0] ceiling;
    if (width >= PIPE_CNT_MAX_W) begin
      ceiling = '1;
    end else begin
      ceiling = (64'd1 << width) - 64'd1;
    end
    if (value >= ceiling) begin
      return value;
    end
    return value + 64'd1;
  endfunction

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One payload + valid register of an elastic pipeline stage.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset, clears payload and valid
//   clr       : synchronous squash, clears payload and valid
//   load      : take src_valid / src_data this edge (ignored while clr)
//   src_valid : valid bit of the upstream source
//   src_data  : payload of the upstream source
//   valid     : registered valid bit
//   data      : registered payload
// -----------------------------------------------------------------------------
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = 57
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (clr) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= src_valid;
      // A bubble moving in only drops the valid bit; the stale payload is
      // kept so the data path does not toggle on empty cycles.
      if (src_valid) begin
        data_reg <= src_data;
      end
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule : pipe_slot

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Elastic inter-stage pipeline register: DEPTH payload slots with per-slot
// valid bits, valid/ready handshake, freeze (stall), flush (squash) and
// saturating stall / flush event counters for profiling.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   in_valid  : upstream payload valid
//   in_data   : upstream payload
//   in_ready  : slot 0 can accept this cycle
//   out_valid : last slot holds a payload and the stage is not frozen
//   out_data  : payload of the last slot
//   out_ready : downstream accepts this cycle
//   freeze    : hazard stall, every slot holds
//   flush     : squash every slot, concurrent input discarded
//   cnt_clr   : synchronous clear of both counters
//   stall_cnt : saturating count of stalled cycles
//   flush_cnt : saturating count of flush cycles
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 57,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              freeze,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // ---------------------------------------------------------------------------
  // Mode decode
  // ---------------------------------------------------------------------------
  stage_mode_e mode;

  always_comb begin
    mode = MODE_RUN;
    if (flush) begin
      mode = MODE_FLUSH;
    end else if (freeze) begin
      mode = MODE_FREEZE;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot chain
  // acc[i] : slot i may take a new value this cycle. An empty slot always
  // accepts, so bubbles collapse instead of travelling down the pipe.
  // ---------------------------------------------------------------------------
  logic [DEPTH:0]    acc;
  logic [DEPTH-1:0]  slot_valid;
  logic [DATA_W-1:0] slot_data [DEPTH];

  assign acc[DEPTH] = out_ready;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic              src_valid;
      logic [DATA_W-1:0] src_data;

      if (gi == 0) begin : g_head
        assign src_valid = in_valid;
        assign src_data  = in_data;
      end else begin : g_body
        assign src_valid = slot_valid[gi-1];
        assign src_data  = slot_data[gi-1];
      end

      assign acc[gi] = !slot_valid[gi] || acc[gi+1];

      pipe_slot #(
        .DATA_W (DATA_W)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .clr       (mode == MODE_FLUSH),
        .load      ((mode == MODE_RUN) && acc[gi]),
        .src_valid (src_valid),
        .src_data  (src_data),
        .valid     (slot_valid[gi]),
        .data      (slot_data[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = !freeze && !flush && acc[0];
  assign out_valid = slot_valid[DEPTH-1] && !freeze;
  assign out_data  = slot_data[DEPTH-1];

  // ---------------------------------------------------------------------------
  // Profiling counters
  // A stalled cycle is either a hazard freeze or a held output that the
  // downstream stage refused. Flush does not mask either condition.
  // ---------------------------------------------------------------------------
  logic             stall_event;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_next;

  assign stall_event = freeze || (slot_valid[DEPTH-1] && !out_ready);

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (cnt_clr) begin
      stall_cnt_next = '0;
      flush_cnt_next = '0;
    end else begin
      if (stall_event) begin
        stall_cnt_next = CNT_W'(sat_inc(PIPE_CNT_MAX_W'(stall_cnt_reg), CNT_W));
      end
      if (flush) begin
        flush_cnt_next = CNT_W'(sat_inc(PIPE_CNT_MAX_W'(flush_cnt_reg), CNT_W));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Three instances share one stimulus bus: DEPTH=2, DEPTH=3, and DEPTH=1 with
// 2-bit counters. 'sel' picks which instance the scoreboard follows.
// Inputs change on the falling edge; checks run 1-2 time units later.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          freeze;
  logic          flush;
  logic          cnt_clr;

  logic          rdy_a, ov_a, rdy_b, ov_b, rdy_c, ov_c;
  logic [DW-1:0] od_a, od_b, od_c;
  logic [15:0]   sc_a, fc_a, sc_b, fc_b;
  logic [1:0]    sc_c, fc_c;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .DEPTH(2), .CNT_W(16)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_a), .out_valid(ov_a), .out_data(od_a), .out_ready(out_ready),
    .freeze(freeze), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(sc_a), .flush_cnt(fc_a)
  );

  pipe_stage_reg #(.DATA_W(DW), .DEPTH(3), .CNT_W(16)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_b), .out_valid(ov_b), .out_data(od_b), .out_ready(out_ready),
    .freeze(freeze), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(sc_b), .flush_cnt(fc_b)
  );

  pipe_stage_reg #(.DATA_W(DW), .DEPTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_c), .out_valid(ov_c), .out_data(od_c), .out_ready(out_ready),
    .freeze(freeze), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(sc_c), .flush_cnt(fc_c)
  );

  int            sel = 0;
  logic          m_rdy, m_ov;
  logic [DW-1:0] m_od;
  logic [15:0]   m_sc, m_fc;

  assign m_rdy = (sel == 0) ? rdy_a : (sel == 1) ? rdy_b : rdy_c;
  assign m_ov  = (sel == 0) ? ov_a  : (sel == 1) ? ov_b  : ov_c;
  assign m_od  = (sel == 0) ? od_a  : (sel == 1) ? od_b  : od_c;
  assign m_sc  = (sel == 0) ? sc_a  : (sel == 1) ? sc_b  : {14'd0, sc_c};
  assign m_fc  = (sel == 0) ? fc_a  : (sel == 1) ? fc_b  : {14'd0, fc_c};

  int            checks   = 0;
  int            failures = 0;
  int            sb_pops  = 0;
  bit            sb_en    = 1'b0;
  logic [DW-1:0] sb_q [$];

  // Scoreboard: accepted inputs are queued, delivered outputs are compared
  // against the oldest queued payload.
  always @(negedge clk) begin
    logic [DW-1:0] exp_d;
    #2;
    if (sb_en && rst) begin
      if (in_valid && m_rdy) begin
        sb_q.push_back(in_data);
        $display("sb push data=%h", in_data);
      end
      if (m_ov && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow: got data=%h expected no output", m_od);
        end else begin
          exp_d = sb_q.pop_front();
          sb_pops++;
          if (m_od !== exp_d) begin
            failures++;
            $display("FAIL sb_data: got %h expected %h", m_od, exp_d);
          end else begin
            $display("sb pop data=%h ok", m_od);
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    freeze    = 1'b0;
    flush     = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  task automatic apply_reset(input int target);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sel = target;
    sb_q.delete();
    sb_pops = 0;
  endtask

  task automatic test_reset();
    sb_en = 1'b0;
    apply_reset(0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      in_valid = (k <= 2);
      in_data  = (k == 1) ? 16'h00A1 : 16'h00A2;
      #1;
    end
    checks++;
    if (m_ov !== 1'b1 || m_od !== 16'h00A1) begin
      failures++;
      $display("FAIL reset_pre_out: got v=%b d=%h expected v=1 d=00a1", m_ov, m_od);
    end
    checks++;
    if (m_sc !== 16'd1 || m_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_pre_state: got stall=%0d rdy=%b expected stall=1 rdy=0", m_sc, m_rdy);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (m_ov !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", m_ov); end
    checks++;
    if (m_od !== 16'h0) begin failures++; $display("FAIL reset_out_data: got %h expected 0000", m_od); end
    checks++;
    if (m_sc !== 16'd0 || m_fc !== 16'd0) begin
      failures++;
      $display("FAIL reset_counters: got stall=%0d flush=%0d expected 0 0", m_sc, m_fc);
    end
    checks++;
    if (m_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", m_rdy); end
    $display("test_reset done");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_streaming();
    apply_reset(1);
    sb_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (k <= 4);
      in_data   = DW'(k);
      #1;
      checks++;
      if (m_rdy !== 1'b1) begin
        failures++;
        $display("FAIL stream_in_ready: cycle %0d got %b expected 1", k, m_rdy);
      end
      checks++;
      if (m_ov !== (k >= 4 && k <= 7)) begin
        failures++;
        $display("FAIL stream_out_valid: cycle %0d got %b expected %b", k, m_ov, (k >= 4 && k <= 7));
      end
    end
    @(negedge clk);
    idle_inputs();
    #3;
    checks++;
    if (sb_pops !== 4 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL stream_count: got pops=%0d left=%0d expected 4 0", sb_pops, sb_q.size());
    end
    checks++;
    if (m_sc !== 16'd0) begin failures++; $display("FAIL stream_stall_cnt: got %0d expected 0", m_sc); end
    $display("test_streaming done");
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] seq [3];
    int idx;
    seq = '{16'h00A0, 16'h00B0, 16'h00C0};
    idx = 0;
    apply_reset(0);
    sb_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      out_ready = (k >= 6);
      in_valid  = (idx < 3);
      in_data   = (idx < 3) ? seq[idx] : 16'h0;
      #1;
      if (in_valid) begin
        checks++;
        if (m_rdy !== !(k >= 3 && k <= 5)) begin
          failures++;
          $display("FAIL bp_in_ready: cycle %0d got %b expected %b", k, m_rdy, !(k >= 3 && k <= 5));
        end
      end
      if (in_valid && m_rdy) idx++;
    end
    @(negedge clk);
    idle_inputs();
    #3;
    checks++;
    if (sb_pops !== 3 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL bp_count: got pops=%0d left=%0d expected 3 0", sb_pops, sb_q.size());
    end
    checks++;
    if (m_sc !== 16'd3) begin failures++; $display("FAIL bp_stall_cnt: got %0d expected 3", m_sc); end
    $display("test_backpressure done");
  endtask

  task automatic test_freeze();
    apply_reset(0);
    sb_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k <= 2) begin
        in_valid = 1'b1;
        in_data  = (k == 1) ? 16'h0F01 : 16'h0F02;
      end
      cnt_clr = (k == 3);
      if (k >= 4 && k <= 6) begin
        freeze   = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h00EE;
      end
      out_ready = (k >= 8);
      #1;
      if (k >= 4 && k <= 6) begin
        checks++;
        if (m_ov !== 1'b0 || m_rdy !== 1'b0 || m_od !== 16'h0F01) begin
          failures++;
          $display("FAIL freeze_hold: cycle %0d got v=%b rdy=%b d=%h expected 0 0 0f01", k, m_ov, m_rdy, m_od);
        end
      end
      if (k == 7) begin
        checks++;
        if (m_sc !== 16'd3) begin failures++; $display("FAIL freeze_stall_cnt: got %0d expected 3", m_sc); end
        checks++;
        if (m_ov !== 1'b1 || m_od !== 16'h0F01) begin
          failures++;
          $display("FAIL freeze_release: got v=%b d=%h expected 1 0f01", m_ov, m_od);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    #3;
    checks++;
    if (sb_pops !== 2 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL freeze_count: got pops=%0d left=%0d expected 2 0", sb_pops, sb_q.size());
    end
    $display("test_freeze done");
  endtask

  task automatic test_flush_freeze();
    apply_reset(0);
    sb_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k <= 2) begin
        in_valid = 1'b1;
        in_data  = (k == 1) ? 16'h0E01 : 16'h0E02;
      end
      if (k == 3) begin
        flush    = 1'b1;
        freeze   = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0E03;
      end
      if (k == 5) begin
        in_valid = 1'b1;
        in_data  = 16'h0E04;
      end
      out_ready = (k >= 4);
      #1;
      if (k == 3) begin
        checks++;
        if (m_rdy !== 1'b0) begin failures++; $display("FAIL flush_in_ready: got %b expected 0", m_rdy); end
        // The queued payloads are squashed, so the scoreboard forgets them.
        sb_q.delete();
      end
      if (k == 4) begin
        checks++;
        if (m_ov !== 1'b0 || m_od !== 16'h0) begin
          failures++;
          $display("FAIL flush_empty: got v=%b d=%h expected 0 0000", m_ov, m_od);
        end
        checks++;
        if (m_fc !== 16'd1) begin failures++; $display("FAIL flush_cnt: got %0d expected 1", m_fc); end
        checks++;
        if (m_rdy !== 1'b1) begin failures++; $display("FAIL flush_resume_ready: got %b expected 1", m_rdy); end
      end
    end
    @(negedge clk);
    idle_inputs();
    #3;
    checks++;
    if (sb_pops !== 1 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL flush_count: got pops=%0d left=%0d expected 1 0", sb_pops, sb_q.size());
    end
    $display("test_flush_freeze done");
  endtask

  task automatic test_saturation();
    sb_en = 1'b0;
    apply_reset(2);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      idle_inputs();
      freeze  = (k <= 6);
      cnt_clr = (k == 8);
      #1;
      if (k <= 7) begin
        checks++;
        if (m_sc !== ((k - 1 > 3) ? 16'd3 : 16'(k - 1))) begin
          failures++;
          $display("FAIL sat_stall: cycle %0d got %0d expected %0d", k, m_sc, (k - 1 > 3) ? 3 : k - 1);
        end
      end
      if (k == 9) begin
        checks++;
        if (m_sc !== 16'd0) begin failures++; $display("FAIL sat_clear: got %0d expected 0", m_sc); end
      end
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      idle_inputs();
      flush = (k <= 4);
      #1;
    end
    checks++;
    if (m_fc !== 16'd3 || m_sc !== 16'd0) begin
      failures++;
      $display("FAIL sat_flush: got flush=%0d stall=%0d expected 3 0", m_fc, m_sc);
    end
    $display("test_saturation done");
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_streaming();
    test_backpressure();
    test_freeze();
    test_flush_freeze();
    test_saturation();
    sb_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_pipe_stage_reg
